// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack sequencer: operation encodings, FSM states
// and the small helpers used by the sequencer and its bound checker.
package stack_seq_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDSP,
        S_MEM,
        S_WB,
        S_ERR
    } state_e;

    // PUSH and CALL both store a word and move SP down; POP and RET move it up.
    function automatic logic is_store(input op_e op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_bound_chk.sv
// Combinational SP arithmetic and bounds check for one stack operation:
// produces the updated SP, the memory word address and the error flag.
module stack_bound_chk
    import stack_seq_pkg::*;
#(
    parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
    input  logic [31:0] sp,
    input  op_e         op,
    output logic [31:0] next_sp,
    output logic [31:0] mem_addr,
    output logic        err
);

    logic [32:0] sp_dec;
    logic [32:0] sp_inc;
    logic        misaligned;

    // The extra bit catches wrap-around below zero or above 2^32.
    assign sp_dec     = {1'b0, sp} - 33'(WORD_BYTES);
    assign sp_inc     = {1'b0, sp} + 33'(WORD_BYTES);
    assign misaligned = |sp[1:0];

    // NOTE: every output gets a value on every path of the always_comb, so no latch can be inferred.
    always_comb begin
        next_sp  = sp_inc[31:0];
        mem_addr = {sp[31:2], 2'b00};
        err      = misaligned || (sp_inc > {1'b0, STACK_BASE});
        if (is_store(op)) begin
            next_sp  = sp_dec[31:0];
            mem_addr = {sp_dec[31:2], 2'b00};
            err      = misaligned || sp_dec[32] || (sp_dec[31:0] < STACK_LIMIT);
        end
    end

endmodule

// File: rtl/stack_seq.sv
// Multi-cycle PUSH/POP/CALL/RET sequencer: reads SP from the register bank,
// performs one data-memory access and writes back SP, a GPR or the PC.
module stack_seq
    import stack_seq_pkg::*;
#(
    parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  dst,
    input  logic [31:0] data_in,
    input  logic [31:0] pc_next,
    input  logic [31:0] sp_in,
    output logic        readSP,
    output logic        writeSP,
    output logic [31:0] write_dataSP,
    output logic        writeReg,
    output logic [4:0]  dr,
    output logic [31:0] write_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        pc_load,
    output logic [31:0] pc_value,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_e      state;
    op_e         op_q;
    logic [4:0]  dst_q;
    logic [31:0] data_q;
    logic [31:0] pc_q;
    logic [31:0] sp_next_q;

    logic [31:0] chk_next_sp;
    logic [31:0] chk_addr;
    logic        chk_err;

    stack_bound_chk #(
        .STACK_BASE  (STACK_BASE),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_bound_chk (
        .sp       (sp_in),
        .op       (op_q),
        .next_sp  (chk_next_sp),
        .mem_addr (chk_addr),
        .err      (chk_err)
    );

    // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            op_q         <= OP_PUSH;
            dst_q        <= '0;
            data_q       <= '0;
            pc_q         <= '0;
            sp_next_q    <= '0;
            readSP       <= 1'b0;
            writeSP      <= 1'b0;
            write_dataSP <= '0;
            writeReg     <= 1'b0;
            dr           <= '0;
            write_data   <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            pc_load      <= 1'b0;
            pc_value     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            // Single-cycle strobes default low; only the WB/ERR transitions raise them.
            writeSP  <= 1'b0;
            writeReg <= 1'b0;
            pc_load  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op_e'(op);
                        dst_q  <= dst;
                        data_q <= data_in;
                        pc_q   <= pc_next;
                        readSP <= 1'b1;
                        busy   <= 1'b1;
                        state  <= S_RDSP;
                    end
                end

                S_RDSP: begin
                    readSP    <= 1'b0;
                    sp_next_q <= chk_next_sp;
                    if (chk_err) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store(op_q);
                        mem_addr  <= chk_addr;
                        mem_wdata <= (op_q == OP_CALL) ? pc_q :
                                     (op_q == OP_PUSH) ? data_q : 32'h0;
                        state     <= S_MEM;
                    end
                end

                S_MEM: begin
                    if (mem_ready) begin
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        writeSP      <= 1'b1;
                        write_dataSP <= sp_next_q;
                        done         <= 1'b1;
                        if (op_q == OP_POP) begin
                            writeReg   <= 1'b1;
                            dr         <= dst_q;
                            write_data <= mem_rdata;
                        end
                        if (op_q == OP_RET) begin
                            pc_load  <= 1'b1;
                            pc_value <= mem_rdata;
                        end
                        state <= S_WB;
                    end
                end

                S_WB, S_ERR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    readSP  <= 1'b0;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: directed vector table, reset/start corner
// sequences and randomized ops against an arithmetic reference model.
module tb_stack_seq;
    import stack_seq_pkg::*;

    localparam logic [31:0] STACK_BASE  = 32'h0000_1000;
    localparam logic [31:0] STACK_LIMIT = 32'h0000_0800;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  dst;
    logic [31:0] data_in;
    logic [31:0] pc_next;
    logic [31:0] sp_in;
    logic        readSP;
    logic        writeSP;
    logic [31:0] write_dataSP;
    logic        writeReg;
    logic [4:0]  dr;
    logic [31:0] write_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        pc_load;
    logic [31:0] pc_value;
    logic        busy;
    logic        done;
    logic        err;

    stack_seq #(
        .STACK_BASE  (STACK_BASE),
        .STACK_LIMIT (STACK_LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .dst          (dst),
        .data_in      (data_in),
        .pc_next      (pc_next),
        .sp_in        (sp_in),
        .readSP       (readSP),
        .writeSP      (writeSP),
        .write_dataSP (write_dataSP),
        .writeReg     (writeReg),
        .dr           (dr),
        .write_data   (write_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .pc_load      (pc_load),
        .pc_value     (pc_value),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic any_output();
        return readSP | writeSP | (|write_dataSP) | writeReg | (|dr) | (|write_data) |
               mem_req | mem_we | (|mem_addr) | (|mem_wdata) | pc_load | (|pc_value) |
               busy | done | err;
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [31:0] sp;
        logic [31:0] data;
        logic [31:0] pc;
        logic [4:0]  dst;
        logic [31:0] rdata;
        int          waits;
        logic        exp_err;
        logic [31:0] exp_sp;
        logic [31:0] exp_addr;
        int          exp_lat;
    } vec_t;

    // Reference model: stack rules expressed with plain signed 64-bit arithmetic.
    function automatic void model(inout vec_t v);
        longint s;
        bit     store;
        s     = longint'(v.sp);
        store = (v.op == 2'b00) || (v.op == 2'b10);
        v.exp_err = (v.sp % 4) != 0;
        if (store) begin
            v.exp_err  = v.exp_err || (s - 4 < longint'(STACK_LIMIT));
            v.exp_sp   = v.sp - 32'd4;
            v.exp_addr = v.sp - 32'd4;
        end else begin
            v.exp_err  = v.exp_err || (s + 4 > longint'(STACK_BASE));
            v.exp_sp   = v.sp + 32'd4;
            v.exp_addr = v.sp;
        end
        v.exp_lat = v.exp_err ? 2 : 3 + v.waits;
    endfunction

    // Entered and left just after a rising edge; cycle 0 is the start cycle.
    task automatic run_op(input string tag, input vec_t v, input bit hold_start);
        int          done_cyc = -1;
        int          done_cnt = 0, rd_cnt = 0, wsp_cnt = 0, wr_cnt = 0, pl_cnt = 0, req_cnt = 0;
        logic        err_at = 1'b0, req_we = 1'b0, unstable = 1'b0, busy_after = 1'b0;
        logic [31:0] wsp_val = '0, wr_val = '0, pl_val = '0, req_addr = '0, req_wdata = '0;
        logic [4:0]  wr_dr = '0;
        bit          is_pop, is_ret, is_call;
        op = v.op; dst = v.dst; data_in = v.data; pc_next = v.pc; sp_in = v.sp;
        mem_ready = 1'b0; mem_rdata = $urandom; start = 1'b1;
        is_pop = (v.op == 2'b01); is_ret = (v.op == 2'b11); is_call = (v.op == 2'b10);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = cyc; err_at = err; end
            end
            if (readSP) rd_cnt++;
            if (writeSP) begin wsp_cnt++; wsp_val = write_dataSP; end
            if (writeReg) begin wr_cnt++; wr_val = write_data; wr_dr = dr; end
            if (pc_load) begin pl_cnt++; pl_val = pc_value; end
            if (mem_req) begin
                if (req_cnt == 0) begin
                    req_addr = mem_addr; req_we = mem_we; req_wdata = mem_wdata;
                end else if (mem_addr !== req_addr || mem_we !== req_we || mem_wdata !== req_wdata) begin
                    unstable = 1'b1;
                end
                req_cnt++;
            end
            if (done_cyc > 0 && cyc > done_cyc && busy) busy_after = 1'b1;
            mem_ready = mem_req && (req_cnt > v.waits);
            mem_rdata = mem_ready ? v.rdata : $urandom;
            start     = hold_start && (done_cyc < 0 || cyc == done_cyc);
            if (done_cyc > 0 && cyc >= done_cyc + 2) break;
        end
        start = 1'b0; mem_ready = 1'b0;
        check({tag, " latency"},     done_cyc, v.exp_lat);
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " err"},         err_at, v.exp_err);
        check({tag, " readSP"},      rd_cnt, 1);
        check({tag, " writeSP_cnt"}, wsp_cnt, v.exp_err ? 0 : 1);
        check({tag, " busy_after"},  busy_after, 0);
        if (!v.exp_err) begin
            check({tag, " write_dataSP"}, wsp_val, v.exp_sp);
            check({tag, " mem_req_cycles"}, req_cnt, v.waits + 1);
            check({tag, " mem_addr"},  req_addr, v.exp_addr);
            check({tag, " mem_we"},    req_we, (v.op == 2'b00) || is_call);
            check({tag, " mem_stable"}, unstable, 0);
            if (req_we) check({tag, " mem_wdata"}, req_wdata, is_call ? v.pc : v.data);
        end else begin
            check({tag, " no_mem_req"}, req_cnt, 0);
        end
        check({tag, " writeReg_cnt"}, wr_cnt, (is_pop && !v.exp_err) ? 1 : 0);
        if (is_pop && !v.exp_err) begin
            check({tag, " write_data"}, wr_val, v.rdata);
            check({tag, " dr"}, wr_dr, v.dst);
        end
        check({tag, " pc_load_cnt"}, pl_cnt, (is_ret && !v.exp_err) ? 1 : 0);
        if (is_ret && !v.exp_err) check({tag, " pc_value"}, pl_val, v.rdata);
    endtask

    vec_t vecs[11];

    initial begin
        vec_t v;
        int   r;

        //          op     sp            data         pc           dst rdata        w  err sp            addr          lat
        vecs[0]  = '{2'b00, 32'h0000_1000, 32'h0000_DEAD, 32'h0,      5'd0, 32'h0,      0, 0, 32'h0000_0FFC, 32'h0000_0FFC, 3};
        vecs[1]  = '{2'b01, 32'h0000_0FFC, 32'h0,      32'h0,      5'd5, 32'h0000_DEAD, 2, 0, 32'h0000_1000, 32'h0000_0FFC, 5};
        vecs[2]  = '{2'b10, 32'h0000_0FFC, 32'h0,      32'h0000_0040, 5'd0, 32'h0,      0, 0, 32'h0000_0FF8, 32'h0000_0FF8, 3};
        vecs[3]  = '{2'b11, 32'h0000_0FF8, 32'h0,      32'h0,      5'd0, 32'h0000_0040, 1, 0, 32'h0000_0FFC, 32'h0000_0FF8, 4};
        vecs[4]  = '{2'b00, 32'h0000_0800, 32'h1234_5678, 32'h0,   5'd0, 32'h0,      0, 1, 32'h0,         32'h0,         2};
        vecs[5]  = '{2'b00, 32'h0000_0804, 32'hCAFE_F00D, 32'h0,   5'd0, 32'h0,      0, 0, 32'h0000_0800, 32'h0000_0800, 3};
        vecs[6]  = '{2'b01, 32'h0000_1000, 32'h0,      32'h0,      5'd3, 32'h0,      0, 1, 32'h0,         32'h0,         2};
        vecs[7]  = '{2'b01, 32'h0000_1002, 32'h0,      32'h0,      5'd3, 32'h0,      0, 1, 32'h0,         32'h0,         2};
        vecs[8]  = '{2'b01, 32'h0000_0FFC, 32'h0,      32'h0,      5'd0, 32'h5555_AAAA, 0, 0, 32'h0000_1000, 32'h0000_0FFC, 3};
        vecs[9]  = '{2'b00, 32'h0000_0000, 32'h1,      32'h0,      5'd0, 32'h0,      0, 1, 32'h0,         32'h0,         2};
        vecs[10] = '{2'b11, 32'hFFFF_FFFC, 32'h0,      32'h0,      5'd0, 32'h0,      0, 1, 32'h0,         32'h0,         2};

        reset = 1'b1; start = 1'b0; op = '0; dst = '0; data_in = '0; pc_next = '0;
        sp_in = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero", any_output(), 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", any_output(), 1'b0);

        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Reset while waiting in MEM: everything clears at once and stays quiet.
        op = 2'b00; sp_in = 32'h0000_1000; data_in = 32'h0000_BEEF; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        check("abort mem_req_before_reset", mem_req, 1'b1);
        reset = 1'b1; #1;
        check("abort outputs_zero", any_output(), 1'b0);
        @(posedge clk); #1; reset = 1'b0;
        begin
            int side = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (writeSP || done || busy || mem_req || writeReg || pc_load) side++;
            end
            check("abort no_activity_after", side, 0);
        end

        // start held high through the whole op: only one op, one done.
        v = '{2'b00, 32'h0000_1000, 32'h0000_0077, 32'h0, 5'd0, 32'h0, 1, 0, 32'h0, 32'h0, 0};
        model(v);
        run_op("hold_start", v, 1'b1);

        for (int n = 0; n < 40; n++) begin
            v.op = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            case (r)
                0: v.sp = $urandom & 32'hFFFF_FFFC;
                1: v.sp = 32'h0000_07F0 + 32'(4 * $urandom_range(0, 8));
                2: v.sp = 32'h0000_0FF0 + 32'(4 * $urandom_range(0, 8));
                3: v.sp = (32'h0000_0800 + 32'($urandom_range(0, 32'h7FF))) | 32'h1;
                default: v.sp = 32'h0000_0800 + 32'(4 * $urandom_range(0, 32'h200));
            endcase
            v.data  = $urandom;
            v.pc    = $urandom & 32'hFFFF_FFFC;
            v.dst   = 5'($urandom_range(0, 31));
            v.rdata = $urandom;
            v.waits = $urandom_range(0, 3);
            model(v);
            run_op($sformatf("rand%0d", n), v, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
